// File: rtl/traffic_controller_top_if.sv
// Signal bundle between the intersection controller and its environment:
// sensor/preemption inputs and the registered lamp outputs.
interface traffic_controller_top_if;
  logic pedestrian_request;
  logic emergency;
  logic traffic_red;
  logic traffic_yellow;
  logic traffic_green;
  logic pedestrian_walk;
  logic pedestrian_dont_walk;

  modport master (
    output pedestrian_request, emergency,
    input  traffic_red, traffic_yellow, traffic_green,
    input  pedestrian_walk, pedestrian_dont_walk
  );

  modport slave (
    input  pedestrian_request, emergency,
    output traffic_red, traffic_yellow, traffic_green,
    output pedestrian_walk, pedestrian_dont_walk
  );
endinterface

// File: rtl/traffic_controller_top.sv
// Vehicle/pedestrian light sequencer with request latching and emergency preemption.
// Lamps are flopped from the next-state decode so they track the state register exactly.
module traffic_controller_top #(
  parameter int unsigned GREEN_MIN   = 10,
  parameter int unsigned GREEN_MAX   = 30,
  parameter int unsigned YELLOW_TIME = 4,
  parameter int unsigned RED_TIME    = 10,
  parameter int unsigned WALK_TIME   = 8,
  parameter int unsigned EMERG_CLEAR = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  traffic_controller_top_if.slave   bus
);

  typedef enum logic [2:0] {S_GREEN, S_YELLOW, S_RED, S_WALK, S_EMERG} state_e;

  // Timers load count-1 on entry so a state spans exactly its parameter in cycles.
  localparam logic [7:0] GREEN_LD  = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YELLOW_LD = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] RED_LD    = 8'(RED_TIME - 1);
  localparam logic [7:0] WALK_LD   = 8'(WALK_TIME - 1);
  localparam logic [7:0] EMERG_LD  = 8'(EMERG_CLEAR);
  localparam logic [7:0] PED_WIN   = 8'(GREEN_MAX - GREEN_MIN);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       ped_q, ped_d;
  logic       red_q, red_d, yellow_q, yellow_d, green_q, green_d, walk_q, walk_d;
  logic       req;

  assign req = bus.pedestrian_request;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q - 8'd1;
    ped_d   = ped_q;
    if (bus.emergency) begin
      // Preemption wins over any expiry; holding it keeps the clearance timer full.
      state_d = S_EMERG;
      timer_d = EMERG_LD;
      ped_d   = 1'b0;
    end else begin
      case (state_q)
        S_GREEN: begin
          ped_d = ped_q | req;
          if (timer_q == 8'd0 || (timer_q <= PED_WIN && ped_d)) begin
            state_d = S_YELLOW;
            timer_d = YELLOW_LD;
          end
        end
        S_YELLOW: begin
          ped_d = ped_q | req;
          if (timer_q == 8'd0) begin
            state_d = S_RED;
            timer_d = RED_LD;
          end
        end
        S_RED: begin
          if (ped_q || req) begin
            state_d = S_WALK;
            timer_d = WALK_LD;
            ped_d   = 1'b0;
          end else if (timer_q == 8'd0) begin
            state_d = S_GREEN;
            timer_d = GREEN_LD;
          end
        end
        S_WALK: begin
          if (timer_q == 8'd0) begin
            state_d = S_GREEN;
            timer_d = GREEN_LD;
          end
        end
        S_EMERG: begin
          if (timer_q == 8'd0) begin
            state_d = S_GREEN;
            timer_d = GREEN_LD;
          end
        end
        default: begin
          state_d = S_GREEN;
          timer_d = GREEN_LD;
          ped_d   = 1'b0;
        end
      endcase
    end

    green_d  = (state_d == S_GREEN);
    yellow_d = (state_d == S_YELLOW);
    red_d    = (state_d == S_RED) || (state_d == S_WALK) || (state_d == S_EMERG);
    walk_d   = (state_d == S_WALK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_GREEN;
      timer_q  <= GREEN_LD;
      ped_q    <= 1'b0;
      green_q  <= 1'b1;
      yellow_q <= 1'b0;
      red_q    <= 1'b0;
      walk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      ped_q    <= ped_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
      walk_q   <= walk_d;
    end
  end

  assign bus.traffic_green        = green_q;
  assign bus.traffic_yellow       = yellow_q;
  assign bus.traffic_red          = red_q;
  assign bus.pedestrian_walk      = walk_q;
  assign bus.pedestrian_dont_walk = ~walk_q;

endmodule

// File: tb/tb_traffic_controller_top.sv
// Directed + random bench for traffic_controller_top against a cycle-count reference model.
module tb_traffic_controller_top;
  localparam int GMIN = 10, GMAX = 30, YT = 4, RT = 10, WT = 8, EC = 8;
  // lamp vector order: {red, yellow, green, walk, dont_walk}
  localparam logic [4:0] L_GREEN = 5'b00101, L_YEL = 5'b01001, L_RED = 5'b10001, L_WALK = 5'b10010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  traffic_controller_top_if bus();

  traffic_controller_top #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_TIME(YT),
    .RED_TIME(RT), .WALK_TIME(WT), .EMERG_CLEAR(EC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef enum {M_G, M_Y, M_R, M_W, M_E} ph_t;
  ph_t ph   = M_G;
  int  n    = 1;   // cycle number within current phase, 1 on entry
  int  lo   = 0;   // emergency-low samples seen since last assertion
  bit  pend = 1'b0;

  function automatic logic [4:0] lamps(input ph_t p);
    case (p)
      M_G:     return L_GREEN;
      M_Y:     return L_YEL;
      M_W:     return L_WALK;
      default: return L_RED;
    endcase
  endfunction

  function automatic logic [4:0] obs();
    return {bus.traffic_red, bus.traffic_yellow, bus.traffic_green,
            bus.pedestrian_walk, bus.pedestrian_dont_walk};
  endfunction

  // One clock edge of the light rules, in terms of elapsed cycles per phase.
  task automatic model(input bit r, input bit q, input bit e);
    if (r) begin
      ph = M_G; n = 1; pend = 1'b0;
    end else if (e) begin
      ph = M_E; lo = 0; pend = 1'b0;
    end else begin
      case (ph)
        M_G: begin
          pend = pend | q;
          if (n == GMAX || (n >= GMIN && pend)) begin ph = M_Y; n = 1; end
          else n++;
        end
        M_Y: begin
          pend = pend | q;
          if (n == YT) begin ph = M_R; n = 1; end
          else n++;
        end
        M_R: begin
          pend = pend | q;
          if (pend) begin ph = M_W; n = 1; pend = 1'b0; end
          else if (n == RT) begin ph = M_G; n = 1; end
          else n++;
        end
        M_W: begin
          if (n == WT) begin ph = M_G; n = 1; end
          else n++;
        end
        M_E: begin
          lo++;
          if (lo == EC + 1) begin ph = M_G; n = 1; end
        end
      endcase
    end
  endtask

  task automatic check_vec(input string tag, input logic [4:0] o, input logic [4:0] x);
    n_cmp++;
    assert (o === x) else begin
      n_bad++;
      $error("FAIL %s: lamps got %b expected %b", tag, o, x);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int x);
    n_cmp++;
    assert (o === x) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, o, x);
    end
  endtask

  task automatic tick(input bit r, input bit q, input bit e, input string tag);
    rst = r;
    bus.pedestrian_request = q;
    bus.emergency = e;
    @(posedge clk);
    model(r, q, e);
    #1;
    check_vec(tag, obs(), lamps(ph));
  endtask

  // Idle until the lamps change; the count includes the changing edge.
  task automatic run_len(input string tag, input int exp);
    logic [4:0] v;
    int k;
    v = obs();
    k = 0;
    do begin
      tick(1'b0, 1'b0, 1'b0, tag);
      k++;
    end while (obs() === v && k < 300);
    check_int(tag, k, exp);
  endtask

  initial begin
    bus.pedestrian_request = 1'b0;
    bus.emergency = 1'b0;

    tick(1'b1, 1'b0, 1'b0, "reset0");
    tick(1'b1, 1'b0, 1'b0, "reset1");
    check_vec("reset_lamps", obs(), L_GREEN);

    // Request just after release: green ends at GREEN_MIN, then short red into walk.
    tick(1'b0, 1'b0, 1'b0, "rel");
    tick(1'b0, 1'b1, 1'b0, "req");
    run_len("green_min", GMIN - 2);
    check_vec("yellow_on", obs(), L_YEL);
    run_len("yellow_len", YT);
    run_len("red_short", 1);
    check_vec("walk_on", obs(), L_WALK);
    run_len("walk_len", WT);

    // Free-running cycle with no requests.
    run_len("green_max", GMAX);
    run_len("yellow_len2", YT);
    run_len("red_full", RT);
    run_len("green_max2", GMAX);
    run_len("yellow_len3", YT);
    run_len("red_full2", RT);

    // Single-cycle emergency pulse in green.
    tick(1'b0, 1'b0, 1'b1, "emerg_pulse");
    check_vec("emerg_red", obs(), L_RED);
    run_len("emerg_clear", EC + 1);
    check_vec("emerg_green", obs(), L_GREEN);

    // Emergency with simultaneous request: request is dropped.
    tick(1'b0, 1'b1, 1'b1, "emerg_req");
    run_len("emerg_req_clear", EC + 1);
    run_len("green_after_drop", GMAX);

    // Walk interrupted by reset.
    tick(1'b0, 1'b1, 1'b0, "req_yel");
    run_len("yel_rest", YT - 1);
    run_len("red_to_walk", 1);
    tick(1'b0, 1'b0, 1'b0, "walk_a");
    tick(1'b0, 1'b0, 1'b0, "walk_b");
    tick(1'b1, 1'b0, 1'b0, "rst_walk");
    check_vec("rst_walk_lamps", obs(), L_GREEN);

    // Clearance restarted by re-assertion, then reset beats emergency.
    tick(1'b0, 1'b0, 1'b1, "emerg_a");
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, "clear_part");
    tick(1'b0, 1'b0, 1'b1, "emerg_re");
    run_len("clear_restart", EC + 1);
    tick(1'b0, 1'b0, 1'b1, "emerg_b");
    tick(1'b0, 1'b0, 1'b0, "clear_b");
    tick(1'b1, 1'b1, 1'b1, "rst_emerg");
    check_vec("rst_emerg_lamps", obs(), L_GREEN);

    // Emergency on the very edge green would expire.
    for (int i = 0; i < GMAX - 1; i++) tick(1'b0, 1'b0, 1'b0, "green_wait");
    tick(1'b0, 1'b0, 1'b1, "emerg_at_expiry");
    check_vec("emerg_priority", obs(), L_RED);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(199) == 0, $urandom_range(7) == 0, $urandom_range(39) == 0, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/traffic_controller_top.md
TRAFFIC_CONTROLLER_TOP -- requirements
Module: traffic_controller_top

Interface
REQ-001 Parameter GREEN_MIN, 10, minimum cycles in GREEN before a pedestrian request may end it.
REQ-002 Parameter GREEN_MAX, 30, cycles in GREEN with no pending request before moving to YELLOW.
REQ-003 Parameter YELLOW_TIME, 4, cycles in YELLOW.
REQ-004 Parameter RED_TIME, 10, cycles in RED when no pedestrian request is pending.
REQ-005 Parameter WALK_TIME, 8, cycles in WALK.
REQ-006 Parameter EMERG_CLEAR, 8, cycles EMERGENCY is held after emergency deasserts.
REQ-007 All parameters SHALL be in the range 1..255; 8-bit down-counter; GREEN_MIN <= GREEN_MAX.
REQ-008 clk  input  1  single clock; all state changes on rising edge.
REQ-009 rst  input  1  reset; synchronous, active-high.
REQ-010 pedestrian_request  input  1  level/pulse crossing request, sampled each clk edge.
REQ-011 emergency  input  1  emergency preemption, level-sensitive, sampled each clk edge.
REQ-012 traffic_red / traffic_yellow / traffic_green  output  1 each  vehicle lamps.
REQ-013 pedestrian_walk / pedestrian_dont_walk  output  1 each  pedestrian lamps.

Function
REQ-014 States SHALL be GREEN, YELLOW, RED, WALK, EMERGENCY; outputs are registered decodes of state (no input-to-output combinational path).
REQ-015 Lamp decode: GREEN -> green=1; YELLOW -> yellow=1; RED, WALK, EMERGENCY -> red=1; exactly one vehicle lamp high at all times.
REQ-016 pedestrian_walk=1 only in WALK; pedestrian_dont_walk SHALL always equal ~pedestrian_walk.
REQ-017 A 1-bit ped_pending flag SHALL set when pedestrian_request=1 is sampled in GREEN, YELLOW or RED, and clear on entry to WALK.
REQ-018 Each state lasts exactly its parameter count of cycles (state timer loads on entry, transition when timer reaches terminal count).
REQ-019 GREEN -> YELLOW after GREEN_MAX cycles, or after GREEN_MIN cycles if ped_pending (or request sampled that cycle) is set, whichever first.
REQ-020 YELLOW -> RED after YELLOW_TIME cycles.
REQ-021 RED -> WALK on entry if ped_pending is set (RED lasts 1 cycle then); otherwise RED -> GREEN after RED_TIME cycles.
REQ-022 WALK -> GREEN after WALK_TIME cycles; requests sampled during WALK are ignored.
REQ-023 emergency=1 sampled in any state SHALL move to EMERGENCY at that edge (red=1, dont_walk=1 one cycle after assertion); a single-cycle pulse suffices.
REQ-024 EMERGENCY holds while emergency=1; after the first cycle emergency=0 is sampled, it remains for EMERG_CLEAR further cycles, then goes to GREEN with a fresh timer.
REQ-025 Re-assertion of emergency during clearance SHALL restart the clearance hold.
REQ-026 Entry to EMERGENCY SHALL clear ped_pending; pedestrian_request sampled during EMERGENCY is discarded.
REQ-027 Emergency has priority over every timer expiry and pedestrian request on the same edge.

Reset
REQ-028 rst=1 at a clock edge SHALL force GREEN, timer loaded for GREEN, ped_pending=0, regardless of current state or inputs (including mid-WALK or EMERGENCY).
REQ-029 Reset outputs: traffic_green=1, traffic_red=0, traffic_yellow=0, pedestrian_walk=0, pedestrian_dont_walk=1.
REQ-030 Reset SHALL take priority over emergency.

Verification
REQ-031 Reset 2 cycles, release, 1-cycle pedestrian_request next cycle -> one cycle later green=1, dont_walk=1; YELLOW after GREEN_MIN cycles from reset release.
REQ-032 Continuing REQ-031 -> YELLOW 4 cycles, RED 1 cycle, WALK 8 cycles (walk=1, red=1, dont_walk=0), then GREEN.
REQ-033 No requests -> GREEN 30, YELLOW 4, RED 10 cycles repeat; walk never asserts.
REQ-034 1-cycle emergency pulse during GREEN -> next cycle red=1, green=0, dont_walk=1; red persists 8 more cycles, then green=1.
REQ-035 emergency and pedestrian_request high together for 1 cycle -> red=1, walk=0 throughout clearance and the following GREEN; request discarded.
REQ-036 rst asserted mid-WALK and mid-EMERGENCY -> next cycle green=1, walk=0, dont_walk=1.
